// File: rtl/apb_reg_slave.sv
// APB completer with a bank of R/W control registers and read-only status
// registers, programmable wait states, per-register access strobes.
module apb_reg_slave #(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned NUM_RW      = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                             sys_clk,
  input  logic                             rst_n,
  input  logic [23:0]                      paddr,
  input  logic                             pwrite,
  input  logic                             psel,
  input  logic                             penable,
  input  logic [3:0]                       pstrb,
  input  logic [31:0]                      pwdata,
  output logic [31:0]                      prdata,
  output logic                             pready,
  output logic                             pslverr,
  output logic [NUM_RW*32-1:0]             ctrl_out,
  input  logic [(NUM_REGS-NUM_RW)*32-1:0]  sts_in,
  output logic [NUM_REGS-1:0]              wr_stb,
  output logic [NUM_REGS-1:0]              rd_stb
);

  localparam logic [21:0] NUM_REGS_W = 22'(NUM_REGS);
  localparam logic [21:0] NUM_RW_W   = 22'(NUM_RW);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [21:0] lat_idx;
  logic        lat_write;
  logic [3:0]  lat_strb;
  logic [31:0] lat_wdata;
  logic [31:0] ctrl [NUM_RW];

  logic        access;
  logic [21:0] cur_idx;
  logic        cur_write;
  logic [3:0]  cur_strb;
  logic [31:0] cur_wdata;
  logic        enter_resp;
  logic        in_range;
  logic        legal_wr;
  logic        legal_rd;
  logic [31:0] rd_word;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^paddr[1:0];
  assign access = psel & penable;

  // State register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: count down wait states, abort if the master drops psel
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (access) state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT: begin
        if (!psel)           state_nxt = IDLE;
        else if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the very edge that samples the
  // access, so decode must look at the live bus in IDLE and the latch otherwise.
  always_comb begin
    cur_idx    = (state == IDLE) ? paddr[23:2] : lat_idx;
    cur_write  = (state == IDLE) ? pwrite      : lat_write;
    cur_strb   = (state == IDLE) ? pstrb       : lat_strb;
    cur_wdata  = (state == IDLE) ? pwdata      : lat_wdata;
    enter_resp = (state_nxt == RESP);
    in_range   = (cur_idx < NUM_REGS_W);
    legal_wr   = enter_resp & in_range & cur_write & (cur_idx < NUM_RW_W);
    legal_rd   = enter_resp & in_range & ~cur_write;
  end

  // Read mux over control and status registers
  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < NUM_RW; k++)
      if (cur_idx == 22'(k)) rd_word = ctrl[k];
    for (int unsigned j = 0; j < NUM_REGS - NUM_RW; j++)
      if (cur_idx == 22'(NUM_RW + j)) rd_word = sts_in[j*32 +: 32];
  end

  // Request latch, wait counter and registered response/strobes
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_strb  <= '0;
      lat_wdata <= '0;
      prdata    <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      wr_stb    <= '0;
      rd_stb    <= '0;
    end else begin
      if (state == IDLE && access) begin
        lat_idx   <= paddr[23:2];
        lat_write <= pwrite;
        lat_strb  <= pstrb;
        lat_wdata <= pwdata;
        cnt       <= 4'(WAIT_STATES);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      pready  <= enter_resp;
      pslverr <= enter_resp & ~(legal_wr | legal_rd);
      prdata  <= legal_rd ? rd_word : '0;
      wr_stb  <= legal_wr ? (NUM_REGS'(1) << cur_idx) : '0;
      rd_stb  <= legal_rd ? (NUM_REGS'(1) << cur_idx) : '0;
    end
  end

  // Byte-merged write into the addressed control register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_RW; k++) ctrl[k] <= '0;
    end else if (legal_wr) begin
      for (int unsigned k = 0; k < NUM_RW; k++)
        if (cur_idx == 22'(k))
          for (int unsigned b = 0; b < 4; b++)
            if (cur_strb[b]) ctrl[k][8*b +: 8] <= cur_wdata[8*b +: 8];
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl_out
    assign ctrl_out[32*g +: 32] = ctrl[g];
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Self-checking bench for apb_reg_slave: two instances (0 and 3 wait states)
// checked against a register-array reference model.
module tb_apb_reg_slave;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [23:0]  paddr   [2];
  logic         pwrite  [2];
  logic         psel    [2];
  logic         penable [2];
  logic [3:0]   pstrb   [2];
  logic [31:0]  pwdata  [2];
  logic [31:0]  prdata  [2];
  logic         pready  [2];
  logic         pslverr [2];
  logic [255:0] ctrl_out[2];
  logic [255:0] sts_in  [2];
  logic [15:0]  wr_stb  [2];
  logic [15:0]  rd_stb  [2];

  logic [31:0]  mctrl [2][8];
  int           ws [2] = '{0, 3};
  int           total = 0;
  int           bad   = 0;

  always #5 clk = ~clk;

  apb_reg_slave #(.NUM_REGS(16), .NUM_RW(8), .WAIT_STATES(0)) dut0 (
    .sys_clk(clk), .rst_n(rst_n), .paddr(paddr[0]), .pwrite(pwrite[0]),
    .psel(psel[0]), .penable(penable[0]), .pstrb(pstrb[0]), .pwdata(pwdata[0]),
    .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]),
    .ctrl_out(ctrl_out[0]), .sts_in(sts_in[0]), .wr_stb(wr_stb[0]), .rd_stb(rd_stb[0])
  );

  apb_reg_slave #(.NUM_REGS(16), .NUM_RW(8), .WAIT_STATES(3)) dut3 (
    .sys_clk(clk), .rst_n(rst_n), .paddr(paddr[1]), .pwrite(pwrite[1]),
    .psel(psel[1]), .penable(penable[1]), .pstrb(pstrb[1]), .pwdata(pwdata[1]),
    .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]),
    .ctrl_out(ctrl_out[1]), .sts_in(sts_in[1]), .wr_stb(wr_stb[1]), .rd_stb(rd_stb[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus(input int d);
    psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
    paddr[d] = '0; pstrb[d] = '0; pwdata[d] = '0;
  endtask

  // One complete APB transfer (setup + access) with all response checks.
  task automatic xfer(input int d, input logic wr, input logic [23:0] addr,
                      input logic [3:0] strb, input logic [31:0] wd);
    int unsigned idx;
    int          lat;
    logic [31:0] mask, exp_rd;
    logic        exp_err;
    logic [15:0] exp_wstb, exp_rstb;

    idx = int'(addr[23:2]);
    mask = '0;
    for (int b = 0; b < 4; b++) if (strb[b]) mask[8*b +: 8] = 8'hFF;
    exp_rd = '0; exp_err = 1'b0; exp_wstb = '0; exp_rstb = '0;
    if (idx >= 16) begin
      exp_err = 1'b1;
    end else if (wr) begin
      if (idx >= 8) exp_err = 1'b1;
      else begin
        mctrl[d][idx] = (mctrl[d][idx] & ~mask) | (wd & mask);
        exp_wstb = 16'(1) << idx;
      end
    end else begin
      exp_rd   = (idx < 8) ? mctrl[d][idx] : sts_in[d][(idx-8)*32 +: 32];
      exp_rstb = 16'(1) << idx;
    end

    @(posedge clk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pstrb[d] = strb; pwdata[d] = wd;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!pready[d]) check("prdata_wait", 64'(prdata[d]), 64'h0);
    end while (!pready[d] && lat < 40);

    check("latency", 64'(lat), 64'(1 + ws[d]));
    check("prdata", 64'(prdata[d]), 64'(exp_rd));
    check("pslverr", 64'(pslverr[d]), 64'(exp_err));
    check("wr_stb", 64'(wr_stb[d]), 64'(exp_wstb));
    check("rd_stb", 64'(rd_stb[d]), 64'(exp_rstb));
    if (idx < 8) check("ctrl_reg", 64'(ctrl_out[d][idx*32 +: 32]), 64'(mctrl[d][idx]));
    idle_bus(d);

    @(posedge clk); #1;
    check("pready_after", 64'(pready[d]), 64'h0);
    check("prdata_after", 64'(prdata[d]), 64'h0);
    check("stb_after", 64'({wr_stb[d], rd_stb[d]}), 64'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      idle_bus(d);
      sts_in[d] = '0;
      for (int k = 0; k < 8; k++) mctrl[d][k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_prdata", 64'(prdata[d]), 64'h0);
      check("rst_pready", 64'(pready[d]), 64'h0);
      check("rst_pslverr", 64'(pslverr[d]), 64'h0);
      check("rst_stb", 64'({wr_stb[d], rd_stb[d]}), 64'h0);
      check("rst_ctrl_zero", 64'(ctrl_out[d] === '0), 64'h1);
    end
    rst_n = 1'b1;

    // Reset during WAIT of a write to reg1 (3 wait states)
    @(posedge clk); #1;
    psel[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 24'h000004;
    pstrb[1] = 4'hF; pwdata[1] = 32'hDEADBEEF;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstmid_pready_pre", 64'(pready[1]), 64'h0);
    rst_n = 1'b0;
    #1;
    check("rstmid_pready", 64'(pready[1]), 64'h0);
    idle_bus(1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rstmid_no_pready", 64'(pready[1]), 64'h0);
    end
    check("rstmid_reg1", 64'(ctrl_out[1][63:32]), 64'h0);

    // Full write / readback, byte strobes, zero strobe
    xfer(0, 1'b1, 24'h000008, 4'hF, 32'hAABBCCDD);
    check("reg2_full", 64'(ctrl_out[0][95:64]), 64'hAABBCCDD);
    xfer(0, 1'b0, 24'h000008, 4'h0, 32'h0);
    xfer(0, 1'b1, 24'h000008, 4'h5, 32'h11223344);
    check("reg2_merge", 64'(ctrl_out[0][95:64]), 64'hAA22CC44);
    xfer(0, 1'b1, 24'h000008, 4'h0, 32'h55555555);
    check("reg2_nostrb", 64'(ctrl_out[0][95:64]), 64'hAA22CC44);

    // Status read, illegal write to status, out-of-range read
    sts_in[0][63:32] = 32'hF0876543;
    xfer(0, 1'b0, 24'h000024, 4'h0, 32'h0);
    xfer(0, 1'b1, 24'h000024, 4'hF, 32'h01020304);
    xfer(0, 1'b0, 24'h000024, 4'h0, 32'h0);
    xfer(0, 1'b0, 24'h000040, 4'h0, 32'h0);
    xfer(0, 1'b1, 24'h000043, 4'hF, 32'h0BADF00D);

    // Wait-state latency
    xfer(1, 1'b0, 24'h000000, 4'h0, 32'h0);

    // psel dropped during WAIT
    @(posedge clk); #1;
    psel[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 24'h00000C;
    pstrb[1] = 4'hF; pwdata[1] = 32'h12345678;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    check("drop_pready_pre", 64'(pready[1]), 64'h0);
    idle_bus(1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("drop_no_pready", 64'({pready[1], wr_stb[1]}), 64'h0);
    end
    check("drop_reg3", 64'(ctrl_out[1][127:96]), 64'(mctrl[1][3]));
    xfer(1, 1'b1, 24'h00000C, 4'hF, 32'hCAFEF00D);
    xfer(1, 1'b0, 24'h00000C, 4'h0, 32'h0);

    // Write/readback sequence
    xfer(0, 1'b1, 24'h000000, 4'hF, 32'h00C0FFEE);
    xfer(0, 1'b1, 24'h000004, 4'hF, 32'h13579BDF);
    xfer(0, 1'b1, 24'h00001C, 4'hF, 32'h2468ACE0);
    xfer(0, 1'b0, 24'h000000, 4'h0, 32'h0);
    xfer(0, 1'b0, 24'h000004, 4'h0, 32'h0);
    xfer(0, 1'b0, 24'h00001C, 4'h0, 32'h0);

    // Randomized traffic on both instances
    for (int n = 0; n < 80; n++) begin
      int          d;
      logic [23:0] a;
      d = n % 2;
      for (int j = 0; j < 8; j++) sts_in[d][j*32 +: 32] = $urandom;
      a = 24'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = 24'($urandom);
      xfer(d, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
    end

    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 8; k++)
        check("final_ctrl", 64'(ctrl_out[d][k*32 +: 32]), 64'(mctrl[d][k]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
